// File: rtl/sram_ctrl_32to16.sv
// Splits each 32-bit CPU request into two 16-bit SRAM half-word accesses (low half, then high half).
// Accepts a request only in IDLE; resp_valid pulses in the cycle after accept edge + 2; 4 cycles per request.
module sram_ctrl_32to16 #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_wstrb,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              sram_we_n,
  output logic [1:0]        sram_web_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-2:0] word_q, word_d;
  logic [15:0]       wdata_hi_q, wdata_hi_d;
  logic [1:0]        wstrb_hi_q, wstrb_hi_d;
  logic [15:0]       data_lo_q, data_lo_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic [1:0]        sram_web_n_q, sram_web_n_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       sram_wdata_q, sram_wdata_d;

  // Byte-offset bits of the CPU address carry no meaning for word accesses.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    word_d       = word_q;
    wdata_hi_d   = wdata_hi_q;
    wstrb_hi_d   = wstrb_hi_q;
    data_lo_d    = data_lo_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    sram_we_n_d  = sram_we_n_q;
    sram_web_n_d = sram_web_n_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          word_d      = req_addr[ADDR_W:2];
          wdata_hi_d  = req_wdata[31:16];
          wstrb_hi_d  = req_wstrb[3:2];
          sram_addr_d = {req_addr[ADDR_W:2], 1'b0};
          if (req_we) begin
            sram_wdata_d = req_wdata[15:0];
            sram_web_n_d = ~req_wstrb[1:0];
            sram_we_n_d  = ~|req_wstrb[1:0];
          end else begin
            sram_we_n_d  = 1'b1;
            sram_web_n_d = 2'b11;
          end
          state_d = LO;
        end
      end
      LO: begin
        if (!we_q) data_lo_d = sram_rdata;
        sram_addr_d = {word_q, 1'b1};
        if (we_q) begin
          sram_wdata_d = wdata_hi_q;
          sram_web_n_d = ~wstrb_hi_q;
          sram_we_n_d  = ~|wstrb_hi_q;
        end else begin
          sram_we_n_d  = 1'b1;
          sram_web_n_d = 2'b11;
        end
        state_d = HI;
      end
      HI: begin
        sram_we_n_d  = 1'b1;
        sram_web_n_d = 2'b11;
        resp_valid_d = 1'b1;
        if (!we_q) resp_rdata_d = {sram_rdata, data_lo_q};
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      word_q       <= '0;
      wdata_hi_q   <= '0;
      wstrb_hi_q   <= '0;
      data_lo_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      sram_we_n_q  <= 1'b1;
      sram_web_n_q <= 2'b11;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      word_q       <= word_d;
      wdata_hi_q   <= wdata_hi_d;
      wstrb_hi_q   <= wstrb_hi_d;
      data_lo_q    <= data_lo_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_web_n_q <= sram_web_n_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_web_n = sram_web_n_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_ctrl_32to16.sv
// Bench for sram_ctrl_32to16: behavioural SRAM, vector table plus hand-written corner sequences.
module tb_sram_ctrl_32to16;
  localparam int ADDR_W = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_wstrb;
  logic [ADDR_W:0]   req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              sram_we_n;
  logic [1:0]        sram_web_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic [15:0]       sram_rdata;

  sram_ctrl_32to16 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wstrb(req_wstrb), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .sram_we_n(sram_we_n), .sram_web_n(sram_web_n), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wcount = 0;
  logic [31:0] last_rd = 32'h0;
  logic prev_rv = 1'b0;

  logic [15:0] mem [int];

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    int          acc;
    int          wexp;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          we;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic [15:0] exp_lo;
    logic [15:0] exp_hi;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [15:0] rdmem(int a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural SRAM: commits on the rising edge, read data settles before the next edge.
  initial forever begin
    logic [15:0] cur;
    @(posedge clk);
    cyc++;
    if (sram_we_n === 1'b0) begin
      cur = rdmem(int'(sram_addr));
      if (!sram_web_n[0]) cur[7:0]  = sram_wdata[7:0];
      if (!sram_web_n[1]) cur[15:8] = sram_wdata[15:8];
      mem[int'(sram_addr)] = cur;
      wcount++;
    end
  end

  initial forever begin
    @(negedge clk);
    sram_rdata = rdmem(int'(sram_addr));
  end

  // Response monitor / scoreboard.
  initial forever begin
    sb_t e;
    @(negedge clk);
    if (resp_valid === 1'b1) begin
      chk("resp_pulse_single", {31'h0, prev_rv}, 32'h0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_latency", cyc - e.acc, 32'd2);
        if (e.is_rd) begin
          chk("resp_rdata", resp_rdata, e.rdata);
          last_rd = e.rdata;
        end else begin
          chk("write_keeps_rdata", resp_rdata, last_rd);
          chk("write_commit_count", wcount, e.wexp);
        end
      end
    end
    prev_rv = resp_valid;
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_req(input bit we, input logic [20:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] erd);
    int n = 0;
    sb_t e;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    e.is_rd = !we;
    e.rdata = erd;
    e.acc   = cyc + 1;
    e.wexp  = wcount + (we ? ((|ws[1:0] ? 1 : 0) + (|ws[3:2] ? 1 : 0)) : 0);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lo_addr", {12'h0, sram_addr}, {12'h0, a[20:2], 1'b0});
    chk("lo_ready", {31'h0, req_ready}, 32'h0);
    chk("lo_we_n", {31'h0, sram_we_n}, {31'h0, we ? ~|ws[1:0] : 1'b1});
    @(negedge clk);
    chk("hi_addr", {12'h0, sram_addr}, {12'h0, a[20:2], 1'b1});
    chk("hi_ready", {31'h0, req_ready}, 32'h0);
    chk("hi_we_n", {31'h0, sram_we_n}, {31'h0, we ? ~|ws[3:2] : 1'b1});
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last;
    int nacc;
    sb_t e;

    vecs[0] = '{1'b1, 21'h000010, 32'hDEADBEEF, 4'hF, 32'h0,        16'hBEEF, 16'hDEAD};
    vecs[1] = '{1'b0, 21'h000010, 32'h0,        4'h0, 32'hDEADBEEF, 16'h0,    16'h0};
    vecs[2] = '{1'b1, 21'h000020, 32'h12345678, 4'b1001, 32'h0,     16'h0078, 16'h1200};
    vecs[3] = '{1'b0, 21'h000023, 32'h0,        4'h0, 32'h12000078, 16'h0,    16'h0};
    vecs[4] = '{1'b1, 21'h000030, 32'hFFFFFFFF, 4'h0, 32'h0,        16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 21'h000030, 32'h0,        4'h0, 32'h0,        16'h0,    16'h0};
    vecs[6] = '{1'b0, 21'h000010, 32'h0,        4'h0, 32'hDEADBEEF, 16'h0,    16'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wstrb = 4'h0;
    req_addr = '0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst_web_n", {30'h0, sram_web_n}, 32'h3);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", {12'h0, sram_addr}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_rdata);
      if (vecs[i].we) begin
        chk("vec_mem_lo", {16'h0, rdmem(int'({vecs[i].addr[20:2], 1'b0}))}, {16'h0, vecs[i].exp_lo});
        chk("vec_mem_hi", {16'h0, rdmem(int'({vecs[i].addr[20:2], 1'b1}))}, {16'h0, vecs[i].exp_hi});
      end
    end

    // req_valid held high: acceptances must be exactly 4 cycles apart.
    @(negedge clk);
    req_we = 1'b0; req_addr = 21'h000010; req_valid = 1'b1;
    last = -1; nacc = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready === 1'b1) begin
        e.is_rd = 1'b1; e.rdata = 32'hDEADBEEF; e.acc = cyc + 1; e.wexp = 0;
        sb.push_back(e);
        if (last >= 0) chk("b2b_interval", cyc - last, 32'd4);
        last = cyc;
        nacc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_count", nacc, 32'd3);
    drain();

    // Partial strobes touch only the strobed bytes.
    mem[8] = 16'h1111;
    mem[9] = 16'h2222;
    do_req(1'b1, 21'h000010, 32'hAABBCCDD, 4'b0110, 32'h0);
    chk("partial_lo", {16'h0, rdmem(8)}, 32'h0000CC11);
    chk("partial_hi", {16'h0, rdmem(9)}, 32'h000022BB);

    // Highest word address wraps to the last two half-words.
    @(negedge clk);
    mem[20'hFFFFE] = 16'h5678;
    mem[20'hFFFFF] = 16'h1234;
    do_req(1'b0, 21'h1FFFFC, 32'h0, 4'h0, 32'h12345678);

    // Reset during the high half of a read aborts it silently.
    @(negedge clk);
    req_we = 1'b0; req_addr = 21'h000010; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'h0;
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_we_n", {31'h0, sram_we_n}, 32'h1);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    repeat (4) @(negedge clk);
    do_req(1'b0, 21'h000010, 32'h0, 4'h0, 32'h22BBCC11);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_ctrl_32to16.md
Name: sram_ctrl_32to16

Overview:
- Bridges the CPU's 32-bit word memory bus to the 16-bit asynchronous SRAM, which has an active-low access enable and active-low byte write enables.
- Each 32-bit request becomes two sequential half-word SRAM accesses: low half first, then high half.
- Read data is assembled into one 32-bit response.
- Sits directly upstream of the SRAM. Its sram_* ports connect one-to-one to the SRAM's we_n/web_n/addr/wdata/rdata.

Parameters:
- ADDR_W, 20: SRAM half-word address width. The CPU byte address width is ADDR_W+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_wstrb  in  4  byte strobes for a write; bit i covers byte i.
- req_addr  in  ADDR_W+1  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- resp_valid  out  1  one-cycle pulse: read data valid, or write done.
- resp_rdata  out  32  assembled read data; holds its value until the next read response.
- sram_we_n  out  1  SRAM access enable, active-low.
- sram_web_n  out  2  SRAM byte write enables, active-low.
- sram_addr  out  ADDR_W  SRAM half-word address.
- sram_wdata  out  16  SRAM write data.
- sram_rdata  in  16  SRAM combinational read data.

Behaviour:
- Reset values:
  - FSM state = IDLE; req_ready = 1.
  - resp_valid = 0; resp_rdata = 0.
  - sram_we_n = 1; sram_web_n = 2'b11; sram_addr = 0; sram_wdata = 0.
  - Latched request registers cleared.
- All sram_* outputs are registered.
- FSM states and transitions:
  - IDLE: req_ready = 1. On an edge with req_valid=1:
    - latch we, wstrb, wdata and word address W = req_addr[ADDR_W:2];
    - load sram_addr = {W,1'b0};
    - for a write, load sram_wdata = wdata[15:0], sram_web_n = ~wstrb[1:0], sram_we_n = ~|wstrb[1:0]; for a read, load sram_we_n = 1 and sram_web_n = 2'b11;
    - go to LO.
  - LO: req_ready = 0.
    - Read: capture sram_rdata into data_lo at the closing edge.
    - Write: the SRAM commits the low half at the closing edge when sram_we_n = 0.
    - At the closing edge, load the high half: sram_addr = {W,1'b1}, sram_wdata = wdata[31:16], sram_web_n = ~wstrb[3:2], sram_we_n = ~|wstrb[3:2] (write) or 1 (read). Go to HI.
  - HI: capture the high half (read) or commit it (write) at the closing edge. Same edge:
    - sram_we_n = 1, sram_web_n = 2'b11;
    - resp_valid = 1;
    - read only: resp_rdata = {sram_rdata, data_lo};
    - go to RESP.
  - RESP: resp_valid = 1 for exactly this cycle, req_ready = 0. Next edge: resp_valid = 0, go to IDLE.
- Latency: request accepted at edge E0; resp_valid is high in the cycle after edge E0+2. Back-to-back throughput is one request per 4 cycles.
- req_ready depends only on state (no combinational path from req_valid).
- A write with all strobes zero still takes 4 cycles and pulses resp_valid; sram_we_n stays 1 throughout.
- A write with only some strobes set touches only the strobed bytes.
- A write does not change resp_rdata.
- req_* inputs are ignored outside IDLE.
- Address wrap: the maximum word address W = all-ones maps to half-words 2W and 2W+1. There is no overflow carry.
- Reset mid-operation: the edge where rst=1 forces the reset values. The half-access whose commit edge coincides with the reset edge still completes in the SRAM. No further SRAM access occurs and no resp_valid is issued for the aborted request.

Test Plan:
- Reset: hold rst 2 cycles -> req_ready=1, resp_valid=0, sram_we_n=1, sram_web_n=2'b11, resp_rdata=0.
- Full write then read:
  - write addr 0x000010, wdata 0xDEADBEEF, wstrb 4'hF -> SRAM[0x8]=0xBEEF, SRAM[0x9]=0xDEAD; resp_valid pulses one cycle, 3 cycles after accept.
  - read same addr -> resp_rdata=0xDEADBEEF with resp_valid.
- Partial strobe:
  - preload SRAM[0x8]=0x1111, SRAM[0x9]=0x2222;
  - write wdata 0xAABBCCDD, wstrb 4'b0110 -> SRAM[0x8]=0xCC11, SRAM[0x9]=0x22BB; sram_we_n stays 0 in both halves.
- Zero strobe and ready gating:
  - write with wstrb 0 -> sram_we_n never 0, resp_valid still pulses.
  - hold req_valid=1 continuously -> accepts exactly every 4 cycles, req_ready=0 in LO/HI/RESP.
- Top address: read byte address 0x1FFFFC -> sram_addr=0xFFFFE then 0xFFFFF; data assembled from those two half-words.
- Reset mid-read: assert rst during HI -> no resp_valid, state IDLE next cycle, then a new read completes correctly.
